// File: rtl/matmul_pkg.sv
// Shared types and sizes for the byte-serial 3x3 matrix-multiply sequencer.
package matmul_pkg;

    localparam int unsigned ELEM_W    = 8;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned N_ELEM    = 9;
    localparam int unsigned IN_BEATS  = 9;
    localparam int unsigned OUT_BEATS = 18;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned OIDX_W    = 5;
    localparam int unsigned FLAT_A_W  = N_ELEM * ELEM_W;
    localparam int unsigned FLAT_C_W  = N_ELEM * RES_W;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

endpackage

// File: rtl/matmul_byte_unpacker.sv
// Holds the captured 144-bit result and presents it one byte at a time,
// low byte of element 0 first.
module matmul_byte_unpacker
    import matmul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [FLAT_C_W-1:0] data_i,
    input  logic                advance_i,
    output logic [ELEM_W-1:0]   byte_o,
    output logic                last_o
);

    logic [FLAT_C_W-1:0] r_q;
    logic [OIDX_W-1:0]   oidx_q;

    // Result register and byte index; index wraps after the final byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            oidx_q <= '0;
        end else if (load_i) begin
            r_q    <= data_i;
            oidx_q <= '0;
        end else if (advance_i) begin
            oidx_q <= last_o ? '0 : oidx_q + OIDX_W'(1);
        end
    end

    assign byte_o = r_q[{oidx_q, 3'b000} +: ELEM_W];
    assign last_o = (oidx_q == OIDX_W'(OUT_BEATS - 1));

endmodule

// File: rtl/matmul_stream_seq.sv
// Byte-serial sequencer for the 3x3 8-bit matrix-multiply core: loads A and B
// over a valid/ready byte port, pulses the core start, then streams the
// 18-byte result out. Optional B reuse enabled by MATMUL_SEQ_REUSE_B_EN.
module matmul_stream_seq
    import matmul_pkg::*;
#(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned DATA_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic                in_ready_o,
    output logic                out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    input  logic                reuse_b_i,
    output logic                mm_start_o,
    output logic [FLAT_A_W-1:0] mm_a_flat_o,
    output logic [FLAT_A_W-1:0] mm_b_flat_o,
    input  logic [FLAT_C_W-1:0] mm_c_flat_i,
    input  logic                mm_done_i
);

    localparam int unsigned CNT_W = $clog2(START_CYCLES + 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [FLAT_A_W-1:0] a_q;
    logic [FLAT_A_W-1:0] b_q;
    logic                b_loaded_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                mm_start_q;

    logic                accept_c;
    logic                last_in_c;
    logic                skip_b_c;
    logic                load_r_c;
    logic                advance_c;
    logic                last_out_c;
    logic [ELEM_W-1:0]   out_byte_c;

`ifdef MATMUL_SEQ_REUSE_B_EN
    assign skip_b_c = reuse_b_i && b_loaded_q;
`else
    logic unused_reuse_b;
    assign unused_reuse_b = reuse_b_i;
    assign skip_b_c       = 1'b0;
`endif

    assign accept_c  = in_valid_i && in_ready_q;
    assign last_in_c = (idx_q == IDX_W'(IN_BEATS - 1));
    assign load_r_c  = (state_q == ST_CAPTURE) && !mm_done_i;
    assign advance_c = (state_q == ST_OUT) && out_ready_i;

    // Sequencer FSM with registered handshake and core-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD_A;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            b_loaded_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mm_start_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (accept_c) begin
                        a_q[{idx_q, 3'b000} +: ELEM_W] <= in_data_i;
                        if (last_in_c) begin
                            idx_q <= '0;
                            if (skip_b_c) begin
                                state_q    <= ST_RUN;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                                mm_start_q <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                state_q <= ST_LOAD_B;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept_c) begin
                        b_q[{idx_q, 3'b000} +: ELEM_W] <= in_data_i;
                        if (last_in_c) begin
                            idx_q      <= '0;
                            b_loaded_q <= 1'b1;
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            mm_start_q <= 1'b1;
                            cnt_q      <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                        mm_start_q <= 1'b0;
                        state_q    <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!mm_done_i) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i && last_out_c) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_LOAD_A;
                    end
                end
                default: begin
                    state_q     <= ST_LOAD_A;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    mm_start_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result capture and byte-serial readout.
    matmul_byte_unpacker u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_r_c),
        .data_i    (mm_c_flat_i),
        .advance_i (advance_c),
        .byte_o    (out_byte_c),
        .last_o    (last_out_c)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_byte_c;
    assign busy_o      = busy_q;
    assign mm_start_o  = mm_start_q;
    assign mm_a_flat_o = a_q;
    assign mm_b_flat_o = b_q;

endmodule

// File: doc/matmul_stream_seq.md
Name: matmul_stream_seq

Overview:
- Byte-serial sequencer in front of the 3x3 8-bit matrix-multiply core.
- Collects A then B, one 8-bit element per valid/ready beat, into 72-bit flat buffers, then drives the core's start.
- Captures the 144-bit result and streams it out as 18 bytes over a valid/ready port.
- Lets the multiplier sit behind the narrow pin-limited I/O of the tile.

Parameters:
- START_CYCLES, 2, consecutive cycles mm_start is held high per run (minimum 2; the core's registered result lags start by one cycle).
- DATA_W, 8, element width; fixed by the core.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  element byte, row-major, element 0 first
- in_ready  out  1  sequencer accepts a byte this cycle
- out_valid  out  1  output byte valid
- out_data  out  8  result byte
- out_ready  in  1  consumer accepts the byte
- busy  out  1  high in RUN/CAPTURE/OUT
- reuse_b  in  1  skip loading B; honoured only with the optional feature
- mm_start  out  1  to core start
- mm_a_flat  out  72  to core A_flat, element k at [8k+7:8k]
- mm_b_flat  out  72  to core B_flat
- mm_c_flat  in  144  from core C_flat, element k at [16k+15:16k]
- mm_done  in  1  from core done

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=LOAD_A; idx=0; buffers A, B, R = 0; b_loaded=0.
  - Outputs: mm_start=0, out_valid=0, out_data=0, busy=0; in_ready=1 the cycle after reset.
  - rst mid-operation aborts any state, including a partial output stream; no further out_valid until a new run.
- Input accept:
  - A beat is accepted on a clk edge with in_valid && in_ready.
  - The byte is written to element idx of the active buffer; idx increments.
- States and transitions:
  - LOAD_A: in_ready=1. After the 9th beat (idx 8): go to RUN if feature enabled && reuse_b && b_loaded, else to LOAD_B; idx=0.
  - LOAD_B: in_ready=1. After the 9th beat: b_loaded=1, go to RUN.
  - RUN: in_ready=0. mm_start=1 for exactly START_CYCLES cycles, counted by a cycle counter, then go to CAPTURE.
  - CAPTURE: mm_start=0. On the first cycle with mm_done=0: R<=mm_c_flat, go to OUT with oidx=0. A missing mm_done pulse is tolerated.
  - OUT:
    - out_valid=1.
    - out_data = byte oidx of R, i.e. element oidx/2; low byte first when oidx is even, high byte when odd.
    - out_data is held stable while out_valid && !out_ready.
    - On a handshake, oidx increments. After byte 17 is accepted: out_valid=0, go to LOAD_A.
    - The A buffer is retained until overwritten.
- Arithmetic: 16-bit results are truncated modulo 2^16 by the core; the sequencer performs no arithmetic on data.
- mm_a_flat and mm_b_flat are driven continuously from the buffers.
- in_valid while in_ready=0 is ignored and not queued.
- The next run's input phase starts only after the last output byte has been accepted (no overlap).

Optional Feature:
- MATMUL_SEQ_REUSE_B_EN
  - Defined: reuse_b is sampled when the 9th A beat is accepted. If reuse_b=1 and b_loaded=1, LOAD_B is skipped and the previous B is reused.
  - Undefined: reuse_b is ignored and every run loads A then B (18 input beats).

Decomposition:
- Package matmul_pkg:
  - state encoding LOAD_A/LOAD_B/RUN/CAPTURE/OUT
  - N_ELEM=9, IN_BEATS=9, OUT_BEATS=18, element widths 8 and 16
- Sub-module matmul_byte_unpacker: 144-bit register plus 5-bit index producing out_data. Everything else stays in the top.

Test Plan:
- Identity A (bytes 1,0,0,0,1,0,0,0,1) then B=1..9 -> 18 output bytes 01 00 02 00 … 09 00; mm_start high exactly 2 cycles; busy low after the last byte.
- A all 0xFF, B all 0xFF -> every element 0xFA03 (195075 mod 65536); output byte pattern 03 FA repeated 9 times.
- out_ready toggled 1-0-0-1 during OUT -> out_data stable across stalls; no byte lost or duplicated; exactly 18 handshakes.
- in_valid held high during RUN/CAPTURE/OUT with changing in_data -> no buffer changes; in_ready=0 throughout.
- rst asserted after the 5th output byte -> next cycle out_valid=0, state LOAD_A; a fresh run with A=B=identity outputs 01 00 00 00 00 00 00 00 01 00 … (identity).
- With MATMUL_SEQ_REUSE_B_EN: run 1 B=1..9; run 2 sends only 9 A bytes with reuse_b=1, A=2·identity -> C=2,4,…,18; without the macro, the run waits for 9 more beats.
